// File: rtl/uart_tx_scheduler.sv
// Round-robin two-requester word-to-byte scheduler feeding the UART TX frame controller.
// Optional watchdog abort is built when TX_SCHED_TIMEOUT_EN is defined.
module uart_tx_scheduler #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    input  logic [1:0]  req0_len,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    input  logic [1:0]  req1_len,
    output logic        req1_ready,
    output logic [7:0]  P_DATA,
    output logic        DataVLD,
    input  logic        FBUSY,
    output logic        busy,
    output logic        done,
    output logic        done_src,
    output logic        err
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SEND      = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    logic [1:0]  state;
    logic [31:0] data_q;
    logic [1:0]  len_q;
    logic        id_q;
    logic [1:0]  byte_cnt;
    logic [1:0]  nxt_cnt;
    logic        last_grant;
    logic        grant0;
    logic        grant1;
    logic        tmo_hit;

    // On a tie the requester that did not win last time goes first.
    assign grant0  = req0_valid && (!req1_valid || last_grant);
    assign grant1  = req1_valid && (!req0_valid || !last_grant);
    assign nxt_cnt = byte_cnt + 2'd1;

`ifdef TX_SCHED_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] tmo_cnt;
    logic          err_q;
    logic          adv;

    assign adv     = ((state == SEND) && FBUSY) ||
                     ((state == WAIT_DONE) && !FBUSY);
    assign tmo_hit = (state != IDLE) && (tmo_cnt == TMO_LAST);
    assign err     = err_q;

    // Restarts on every state change so it measures time spent in one state.
    always_ff @(posedge CLK) begin
        if (RST || state == IDLE || adv || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= tmo_hit;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            data_q     <= '0;
            len_q      <= '0;
            id_q       <= 1'b0;
            byte_cnt   <= '0;
            last_grant <= 1'b1;
            P_DATA     <= '0;
            DataVLD    <= 1'b0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_src   <= 1'b0;
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            done       <= 1'b0;
            if (tmo_hit) begin
                DataVLD <= 1'b0;
                busy    <= 1'b0;
                state   <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (grant0 || grant1) begin
                            data_q     <= grant1 ? req1_data : req0_data;
                            len_q      <= grant1 ? req1_len : req0_len;
                            id_q       <= grant1;
                            last_grant <= grant1;
                            byte_cnt   <= '0;
                            req0_ready <= grant0;
                            req1_ready <= grant1;
                            P_DATA     <= grant1 ? req1_data[7:0]
                                                 : req0_data[7:0];
                            DataVLD    <= 1'b1;
                            busy       <= 1'b1;
                            state      <= SEND;
                        end
                    end
                    SEND: begin
                        if (FBUSY) begin
                            DataVLD <= 1'b0;
                            state   <= WAIT_DONE;
                        end
                    end
                    WAIT_DONE: begin
                        if (!FBUSY) begin
                            if (byte_cnt == len_q) begin
                                done     <= 1'b1;
                                done_src <= id_q;
                                busy     <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                byte_cnt <= nxt_cnt;
                                P_DATA   <= data_q[{nxt_cnt, 3'b000} +: 8];
                                DataVLD  <= 1'b1;
                                state    <= SEND;
                            end
                        end
                    end
                    default: begin
                        DataVLD <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: requester drivers, frame
// controller model, monitor and a word-level reference model.
module tb_uart_tx_scheduler;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  l;
    } word_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_data, req1_data;
    logic [1:0]  req0_len, req1_len;
    logic        req0_ready, req1_ready;
    logic [7:0]  P_DATA;
    logic        DataVLD;
    logic        FBUSY;
    logic        busy, done, done_src, err;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    word_t      q0[$];
    word_t      q1[$];
    logic [7:0] got_bytes[$];
    logic       got_grants[$];
    logic       got_dones[$];
    int         viol = 0;
    int         err_cnt = 0;
    int         cyc = 0;
    int         vld_rise_cyc = 0;
    int         err_cyc = 0;
    logic       vld_at_err = 1'b0;
    logic       busy_at_err = 1'b0;
    int         fc_lat = 2;
    int         fc_hold = 20;
    bit         fc_stuck = 0;

    uart_tx_scheduler #(.TIMEOUT_CYC(16)) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_data(req0_data),
        .req0_len(req0_len), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data),
        .req1_len(req1_len), .req1_ready(req1_ready),
        .P_DATA(P_DATA), .DataVLD(DataVLD), .FBUSY(FBUSY),
        .busy(busy), .done(done), .done_src(done_src), .err(err)
    );

    always #5 CLK = ~CLK;

    // Requesters: present the head word, retire it on the ready pulse.
    initial begin
        req0_valid = 0; req0_data = 0; req0_len = 0;
        req1_valid = 0; req1_data = 0; req1_len = 0;
        forever begin
            @(negedge CLK);
            if (req0_ready && q0.size() > 0) q0.delete(0);
            if (req1_ready && q1.size() > 0) q1.delete(0);
            req0_valid = (q0.size() > 0);
            if (req0_valid) begin
                req0_data = q0[0].d;
                req0_len  = q0[0].l;
            end
            req1_valid = (q1.size() > 0);
            if (req1_valid) begin
                req1_data = q1[0].d;
                req1_len  = q1[0].l;
            end
        end
    end

    // Frame controller: busy fc_lat cycles after a byte is offered, for fc_hold cycles.
    initial begin
        int fc_cnt;
        fc_cnt = 0;
        FBUSY = 1'b0;
        forever begin
            @(negedge CLK);
            if (fc_stuck || RST) begin
                FBUSY = 1'b0;
                fc_cnt = 0;
            end else if (!FBUSY) begin
                if (DataVLD) begin
                    fc_cnt++;
                    if (fc_cnt >= fc_lat) begin
                        FBUSY = 1'b1;
                        fc_cnt = 0;
                    end
                end else begin
                    fc_cnt = 0;
                end
            end else begin
                fc_cnt++;
                if (fc_cnt >= fc_hold) begin
                    FBUSY = 1'b0;
                    fc_cnt = 0;
                end
            end
        end
    end

    // Monitor.
    initial begin
        logic vld_prev, busy_prev;
        logic [7:0] pd_prev;
        vld_prev = 0; busy_prev = 0; pd_prev = 0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (DataVLD && !vld_prev) begin
                got_bytes.push_back(P_DATA);
                vld_rise_cyc = cyc;
            end
            if (DataVLD && vld_prev && P_DATA !== pd_prev) viol++;
            if (req0_ready) begin
                got_grants.push_back(1'b0);
                if (busy_prev) viol++;
            end
            if (req1_ready) begin
                got_grants.push_back(1'b1);
                if (busy_prev) viol++;
            end
            if (req0_ready && req1_ready) viol++;
            if (done) begin
                got_dones.push_back(done_src);
                if (req0_ready || req1_ready) viol++;
            end
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
                vld_at_err = DataVLD;
                busy_at_err = busy;
            end
            vld_prev = DataVLD;
            busy_prev = busy;
            pd_prev = P_DATA;
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic clear_mon();
        got_bytes.delete();
        got_grants.delete();
        got_dones.delete();
        viol = 0;
        err_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        q0.delete();
        q1.delete();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        clear_mon();
    endtask

    task automatic wait_dones(input int n, input int budget, input string nm);
        int i;
        for (i = 0; i < budget && got_dones.size() < n; i++) @(negedge CLK);
        repeat (5) @(negedge CLK);
        chk_cnt++;
        if (got_dones.size() < n)
            $display("FAIL %s_timeout: dones %0d required %0d", nm, got_dones.size(), n);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk_cnt++;
        if (P_DATA !== 8'h00)
            $display("FAIL reset_pdata: got %h required 00", P_DATA);
        else pass_cnt++;
        chk_cnt++;
        if ({DataVLD, req0_ready, req1_ready, busy, done, done_src, err} !== 7'b0)
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {DataVLD, req0_ready, req1_ready, busy, done, done_src, err});
        else pass_cnt++;
        RST = 1'b0;
        clear_mon();
    endtask

    task automatic test_four_byte();
        logic [7:0] exp_b[4];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        fc_lat = 2; fc_hold = 20;
        @(posedge CLK); #1;
        q0.push_back('{32'h44332211, 2'd3});
        wait_dones(1, 2000, "four_byte");
        chk_cnt++;
        if (got_bytes.size() !== 4)
            $display("FAIL four_byte_count: got %0d required 4", got_bytes.size());
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            chk_cnt++;
            if (i >= got_bytes.size() || got_bytes[i] !== exp_b[i])
                $display("FAIL four_byte_b%0d: got %h required %h", i,
                         (i < got_bytes.size()) ? got_bytes[i] : 8'hxx, exp_b[i]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (got_grants.size() !== 1 || got_grants[0] !== 1'b0)
            $display("FAIL four_byte_ready: grants %0d required one on port 0", got_grants.size());
        else pass_cnt++;
        chk_cnt++;
        if (got_dones.size() !== 1 || got_dones[0] !== 1'b0)
            $display("FAIL four_byte_done: dones %0d required one from port 0", got_dones.size());
        else pass_cnt++;
        chk_cnt++;
        if (viol !== 0)
            $display("FAIL four_byte_protocol: violations %0d required 0", viol);
        else pass_cnt++;
    endtask

    task automatic test_short_words();
        for (int k = 0; k < 2; k++) begin
            logic [7:0] exp_b[2];
            exp_b = '{8'hEF, 8'hBE};
            clear_mon();
            fc_lat = 1; fc_hold = 4;
            @(posedge CLK); #1;
            q1.push_back('{32'hDEADBEEF, 2'(k)});
            wait_dones(1, 500, "short");
            chk_cnt++;
            if (got_bytes.size() !== k + 1)
                $display("FAIL short%0d_count: got %0d required %0d", k, got_bytes.size(), k + 1);
            else pass_cnt++;
            for (int i = 0; i <= k; i++) begin
                chk_cnt++;
                if (i >= got_bytes.size() || got_bytes[i] !== exp_b[i])
                    $display("FAIL short%0d_b%0d: got %h required %h", k, i,
                             (i < got_bytes.size()) ? got_bytes[i] : 8'hxx, exp_b[i]);
                else pass_cnt++;
            end
            chk_cnt++;
            if (got_dones.size() !== 1 || got_dones[0] !== 1'b1)
                $display("FAIL short%0d_done: dones %0d required one from port 1", k, got_dones.size());
            else pass_cnt++;
        end
    endtask

    // Word-level model: round-robin over two backlogs, bytes LSB first.
    task automatic run_model(input word_t m0_in[$], input word_t m1_in[$],
                             input bit last_in,
                             output logic exp_g[$], output logic [7:0] exp_b[$]);
        word_t m0[$];
        word_t m1[$];
        word_t w;
        bit    last, g;
        m0 = m0_in; m1 = m1_in; last = last_in;
        exp_g.delete(); exp_b.delete();
        while (m0.size() > 0 || m1.size() > 0) begin
            if (m0.size() > 0 && m1.size() > 0) g = !last;
            else g = (m1.size() > 0);
            if (g) w = m1.pop_front();
            else w = m0.pop_front();
            last = g;
            exp_g.push_back(g);
            for (int b = 0; b <= int'(w.l); b++) exp_b.push_back(w.d[8*b +: 8]);
        end
    endtask

    task automatic check_run(input string nm, input logic exp_g[$],
                             input logic [7:0] exp_b[$]);
        chk_cnt++;
        if (got_grants.size() !== exp_g.size() || got_dones.size() !== exp_g.size())
            $display("FAIL %s_count: grants %0d dones %0d required %0d", nm,
                     got_grants.size(), got_dones.size(), exp_g.size());
        else pass_cnt++;
        for (int i = 0; i < exp_g.size(); i++) begin
            chk_cnt++;
            if (i >= got_grants.size() || got_grants[i] !== exp_g[i] ||
                i >= got_dones.size() || got_dones[i] !== exp_g[i])
                $display("FAIL %s_grant%0d: got %b/%b required %b", nm, i,
                         (i < got_grants.size()) ? got_grants[i] : 1'bx,
                         (i < got_dones.size()) ? got_dones[i] : 1'bx, exp_g[i]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (got_bytes.size() !== exp_b.size())
            $display("FAIL %s_bytes: got %0d bytes required %0d", nm, got_bytes.size(), exp_b.size());
        else pass_cnt++;
        for (int i = 0; i < exp_b.size(); i++) begin
            if (i < got_bytes.size() && got_bytes[i] !== exp_b[i]) begin
                chk_cnt++;
                $display("FAIL %s_byte%0d: got %h required %h", nm, i, got_bytes[i], exp_b[i]);
            end
        end
        chk_cnt++;
        if (viol !== 0 || err_cnt !== 0)
            $display("FAIL %s_protocol: violations %0d err %0d required 0", nm, viol, err_cnt);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        word_t w0[$];
        word_t w1[$];
        logic exp_g[$];
        logic [7:0] exp_b[$];
        fc_lat = 2; fc_hold = 3;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            w0.push_back('{$urandom(), 2'd0});
            w1.push_back('{$urandom(), 2'd0});
        end
        q0 = w0; q1 = w1;
        run_model(w0, w1, 1'b1, exp_g, exp_b);
        wait_dones(4, 1000, "rr");
        check_run("rr", exp_g, exp_b);
    endtask

    task automatic test_reset_mid_word();
        int i;
        fc_lat = 2; fc_hold = 20;
        do_reset();
        @(posedge CLK); #1;
        q0.push_back('{32'h8877_6655, 2'd3});
        for (i = 0; i < 500 && !(got_bytes.size() >= 2 && !DataVLD); i++) @(negedge CLK);
        chk_cnt++;
        if (i >= 500) $display("FAIL rst_mid_wait: second byte not accepted");
        else pass_cnt++;
        RST = 1'b1;
        @(negedge CLK);
        chk_cnt++;
        if ({P_DATA, DataVLD, req0_ready, req1_ready, busy, done, done_src, err} !== 15'h0)
            $display("FAIL rst_mid_outputs: got %h required 0000",
                     {P_DATA, DataVLD, req0_ready, req1_ready, busy, done, done_src, err});
        else pass_cnt++;
        RST = 1'b0;
        repeat (40) @(negedge CLK);
        chk_cnt++;
        if (got_dones.size() !== 0 || err_cnt !== 0)
            $display("FAIL rst_mid_nodone: dones %0d err %0d required 0", got_dones.size(), err_cnt);
        else pass_cnt++;
        clear_mon();
        @(posedge CLK); #1;
        q0.push_back('{32'hA1B2C3D4, 2'd1});
        wait_dones(1, 500, "rst_mid_after");
        chk_cnt++;
        if (got_bytes.size() !== 2 || got_bytes[0] !== 8'hD4 || got_bytes[1] !== 8'hC3)
            $display("FAIL rst_mid_restart: got %0d bytes first %h required D4,C3",
                     got_bytes.size(), (got_bytes.size() > 0) ? got_bytes[0] : 8'hxx);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            word_t w0[$];
            word_t w1[$];
            logic exp_g[$];
            logic [7:0] exp_b[$];
            int n0, n1;
            do_reset();
            fc_lat = $urandom_range(1, 3);
            fc_hold = $urandom_range(1, 6);
            n0 = $urandom_range(0, 4);
            n1 = $urandom_range(1, 4);
            for (int i = 0; i < n0; i++) w0.push_back('{$urandom(), 2'($urandom_range(0, 3))});
            for (int i = 0; i < n1; i++) w1.push_back('{$urandom(), 2'($urandom_range(0, 3))});
            run_model(w0, w1, 1'b1, exp_g, exp_b);
            @(posedge CLK); #1;
            q0 = w0; q1 = w1;
            wait_dones(n0 + n1, 3000, "rand");
            check_run("rand", exp_g, exp_b);
        end
    endtask

`ifdef TX_SCHED_TIMEOUT_EN
    task automatic test_watchdog();
        int i;
        logic exp_g[$];
        logic [7:0] exp_b[$];
        word_t w0[$];
        word_t w1[$];
        do_reset();
        fc_stuck = 1;
        @(posedge CLK); #1;
        q0.push_back('{$urandom(), 2'd0});
        for (i = 0; i < 200 && err_cnt == 0; i++) @(negedge CLK);
        repeat (5) @(negedge CLK);
        chk_cnt++;
        if (err_cnt !== 1)
            $display("FAIL wdog_err_count: got %0d required 1", err_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (err_cyc - vld_rise_cyc !== 16)
            $display("FAIL wdog_latency: got %0d required 16", err_cyc - vld_rise_cyc);
        else pass_cnt++;
        chk_cnt++;
        if (vld_at_err !== 1'b0 || busy_at_err !== 1'b0 || busy !== 1'b0)
            $display("FAIL wdog_idle: vld %b busy %b/%b required 0", vld_at_err, busy_at_err, busy);
        else pass_cnt++;
        chk_cnt++;
        if (got_dones.size() !== 0)
            $display("FAIL wdog_nodone: got %0d required 0", got_dones.size());
        else pass_cnt++;
        fc_stuck = 0;
        fc_lat = 1; fc_hold = 2;
        clear_mon();
        w0.push_back('{$urandom(), 2'd0});
        w1.push_back('{$urandom(), 2'd1});
        run_model(w0, w1, 1'b0, exp_g, exp_b);
        @(posedge CLK); #1;
        q0 = w0; q1 = w1;
        wait_dones(2, 500, "wdog_after");
        check_run("wdog_after", exp_g, exp_b);
    endtask
`else
    task automatic test_watchdog();
        int i, bad;
        do_reset();
        fc_stuck = 1;
        @(posedge CLK); #1;
        q0.push_back('{$urandom(), 2'd0});
        for (i = 0; i < 50 && !DataVLD; i++) @(negedge CLK);
        chk_cnt++;
        if (!DataVLD) $display("FAIL nowdog_start: DataVLD got 0 required 1");
        else pass_cnt++;
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge CLK);
            if (DataVLD !== 1'b1 || err !== 1'b0) bad++;
        end
        chk_cnt++;
        if (bad !== 0)
            $display("FAIL nowdog_hold: bad cycles %0d required 0", bad);
        else pass_cnt++;
        chk_cnt++;
        if (err_cnt !== 0)
            $display("FAIL nowdog_err: err pulses %0d required 0", err_cnt);
        else pass_cnt++;
        fc_stuck = 0;
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_four_byte();
        test_short_words();
        test_round_robin();
        test_reset_mid_word();
        test_random();
        test_watchdog();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
